nco_tdm: RTL and testbench
==========================

# nco_tdm

Time-multiplexed, multi-channel numerically controlled oscillator: successor to the single-channel NCO. A single quarter-wave sine LUT is shared round-robin across `CHANNELS` phase accumulators, producing sin and cos per channel. Per-channel signed step and phase offset are loaded through shadow registers and committed together, which gives coherent multi-channel retuning. It sits between the control/register block and the downstream mixers and DUC/DDC stages.

## Interface
- `LUT_WIDTH`, 32: sample magnitude bits; outputs are `LUT_WIDTH+1` bits signed.
- `LUT_LENGTH`, 6: integer phase bits; one full cycle spans 2^LUT_LENGTH points; minimum 3.
- `PHASE_FRAC`, 2: fractional accumulator bits; `ACC_SIZE = LUT_LENGTH + PHASE_FRAC`.
- `CHANNELS`, 4: channel count, minimum 1; `CH_W = max(1, clog2(CHANNELS))`.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `en`, in, 1: issues the current channel slot this cycle.
- `cfg_we`, in, 1: writes `cfg_step` and `cfg_offset` into the shadow registers of channel `cfg_ch`.
- `cfg_ch`, in, CH_W: target channel. A write with `cfg_ch >= CHANNELS` is ignored.
- `cfg_step`, in, ACC_SIZE+1 signed: phase increment per channel slot, in accumulator LSBs.
- `cfg_offset`, in, LUT_LENGTH: phase offset in LUT index units.
- `cfg_apply`, in, 1: copies all shadow registers into the active registers.
- `cfg_clear`, in, 1: zeroes all accumulators.
- `out_valid`, out, 1: `out_*` holds a new sample.
- `out_ch`, out, CH_W: channel that produced the sample.
- `out_sin`, out, LUT_WIDTH+1 signed.
- `out_cos`, out, LUT_WIDTH+1 signed.

## Operation
- **Slot counter `s`:** increments on each cycle with `en=1`, and wraps from CHANNELS-1 to 0. It holds when `en=0`.
- **Accumulator update:** in an issued cycle, accumulator `acc[s]` (ACC_SIZE bits, unsigned) is read as A. It is then updated to `acc[s] <= (A + step[s]) mod 2^ACC_SIZE`, where `step[s]` is the active step. A negative step rotates the phase backward.
- **Phase index:** `p = (A[ACC_SIZE-1 -: LUT_LENGTH] + offset[s]) mod 2^LUT_LENGTH`. The fractional bits are truncated.
- **LUT contents:** `Q = 2^(LUT_LENGTH-2)`. The LUT holds Q+1 entries, `L[i] = round((2^LUT_WIDTH - 1) * sin(pi*i/(2Q)))` for i = 0..Q. It is generated at elaboration.
- **Sine mapping:** quadrant `q = p[LUT_LENGTH-1:LUT_LENGTH-2]` and `i = p mod Q` select the output:
  - q=0 gives `L[i]`
  - q=1 gives `L[Q-i]`
  - q=2 gives `-L[i]`
  - q=3 gives `-L[Q-i]`
  
  Full-scale is ±(2^LUT_WIDTH - 1); the output never saturates.
- **Cosine:** `cos(p) = sin((p + Q) mod 2^LUT_LENGTH)`, computed with the same mapping.
- **`cfg_we`:** writes the shadow registers only; active values are unchanged.
- **`cfg_apply`:** all active step and offset registers take their shadow values on the same edge.
- **`cfg_clear`:** all accumulators become 0 on that edge. It does not change the slot counter, the step or offset registers, or the pipeline.
- **Reset:** all of the following become 0:
  - accumulators
  - shadow and active step and offset registers
  - `s` and the pipeline valids
  - `out_valid`, `out_ch`, `out_sin`, `out_cos`

## Timing
- **Latency:** 2 cycles. A slot issued in cycle t with accumulator value A produces `out_valid=1` during cycle t+2, with `out_ch` equal to the slot and `out_sin`/`out_cos` computed from A.
- **Output hold:** when `out_valid=0`, the `out_*` data hold their last values.
- **Throughput:** one sample per cycle while `en=1`. Each channel is served every CHANNELS cycles.
- **Bubbles:** `en=0` in cycle t gives `out_valid=0` in cycle t+2. In-flight samples still drain.
- **`cfg_apply` and an issued slot in the same cycle:** that slot uses the old step and offset. The new values take effect from the next issued slot.
- **`cfg_we` and `cfg_apply` in the same cycle:** apply copies the pre-write shadow. The write lands in the shadow only.
- **`cfg_clear` and an issued slot in the same cycle:** the issued slot uses the old A. Every accumulator, including `acc[s]`, ends at 0; clear overrides the update.
- **`reset` mid-run:** everything clears on that edge. `out_valid=0` in the next cycle and stays 0 until two cycles after the first issued slot post-reset. Samples in flight are discarded.

## Test plan
1. **Single channel, unit step.** Setup: CHANNELS=4, defaults. Reset, write ch0 step=4, apply, hold `en=1`.
   - ch0 samples step p = 0, 1, 2, …
   - At p=0: sin=0, cos=+(2^32-1).
   - At p=16: sin=+(2^32-1), cos=0.
   - At p=32: sin=0. At p=48: sin=-(2^32-1).
   - Every 4th `out_valid` is tagged ch0.
2. **Negative step.** ch1 step=-4.
   - ch1 p sequence is 0, 63, 62.
   - `sin(63) = -L[1]`, `sin(62) = -L[2]`.
3. **Offset only.** ch2 step=0, offset=16, apply.
   - Constant sin=+(2^32-1), cos=0.
   - Offset 48 gives sin=-(2^32-1).
4. **Fractional step.** ch3 step=1.
   - p advances by 1 every 4 ch3 samples: 0,0,0,0,1,1,1,1,…
   - `en` toggled 1,0,1: exactly one `out_valid=0` gap, two cycles later.
5. **Shadow and apply.** While ch0 runs at step=4, write step=8.
   - p keeps advancing by 1 per ch0 sample until apply.
   - In the same cycle, write step=12 together with apply: the next ch0 advance is 2. The shadow now holds 12.
6. **Clear and reset mid-run.**
   - `cfg_clear` during running: the next sample of each channel shows p = offset.
   - `reset` asserted for one cycle mid-run: all `out_*` are 0 and `out_valid=0` from the next cycle. With `en=1` after reset, the first valid sample is ch0 with p=0 (step=0).

Source files
------------

// File: rtl/nco_tdm_if.sv
// Bus bundle for nco_tdm: issue enable, per-channel configuration port and sample output.
// The controller drives through master; the oscillator core attaches through slave.
interface nco_tdm_if #(
    parameter int LUT_WIDTH  = 32,
    parameter int LUT_LENGTH = 6,
    parameter int PHASE_FRAC = 2,
    parameter int CHANNELS   = 4
);
    localparam int ACC_SIZE = LUT_LENGTH + PHASE_FRAC;
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                        en;
    logic                        cfg_we;
    logic [CH_W-1:0]             cfg_ch;
    logic signed [ACC_SIZE:0]    cfg_step;
    logic [LUT_LENGTH-1:0]       cfg_offset;
    logic                        cfg_apply;
    logic                        cfg_clear;
    logic                        out_valid;
    logic [CH_W-1:0]             out_ch;
    logic signed [LUT_WIDTH:0]   out_sin;
    logic signed [LUT_WIDTH:0]   out_cos;

    modport master (
        output en, cfg_we, cfg_ch, cfg_step, cfg_offset, cfg_apply, cfg_clear,
        input  out_valid, out_ch, out_sin, out_cos
    );

    modport slave (
        input  en, cfg_we, cfg_ch, cfg_step, cfg_offset, cfg_apply, cfg_clear,
        output out_valid, out_ch, out_sin, out_cos
    );
endinterface

// File: rtl/nco_tdm.sv
// Time-multiplexed multi-channel NCO: one quarter-wave sine ROM shared round-robin
// across CHANNELS phase accumulators, with shadowed step/offset for coherent retuning.
module nco_tdm #(
    parameter int LUT_WIDTH  = 32,
    parameter int LUT_LENGTH = 6,
    parameter int PHASE_FRAC = 2,
    parameter int CHANNELS   = 4
) (
    input  logic          clk,
    input  logic          reset,
    nco_tdm_if.slave      bus
);
    localparam int ACC_SIZE = LUT_LENGTH + PHASE_FRAC;
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int Q        = 2 ** (LUT_LENGTH - 2);
    localparam int AW       = LUT_LENGTH - 1;   // holds addresses 0..Q

    function automatic logic [LUT_WIDTH-1:0] lut_val(input int idx);
        real pi_c;
        real v;
        pi_c = 3.14159265358979323846;
        v = (2.0 ** LUT_WIDTH - 1.0) * $sin(pi_c * real'(idx) / real'(2 * Q));
        return LUT_WIDTH'(longint'(v));
    endfunction

    // Quadrant folding: returns {negate, quarter-table address}.
    function automatic logic [AW:0] quad_map(input logic [LUT_LENGTH-1:0] p);
        logic [AW-1:0] i_ext;
        logic [AW-1:0] addr;
        i_ext = AW'(p[LUT_LENGTH-3:0]);
        addr  = p[LUT_LENGTH-2] ? (AW'(Q) - i_ext) : i_ext;
        return {p[LUT_LENGTH-1], addr};
    endfunction

    logic [LUT_WIDTH-1:0] lut [Q+1];

    genvar gi;
    generate
        for (gi = 0; gi <= Q; gi++) begin : g_lut
            localparam logic [LUT_WIDTH-1:0] LVAL = lut_val(gi);
            assign lut[gi] = LVAL;
        end
    endgenerate

    logic [ACC_SIZE-1:0]       acc_reg     [CHANNELS];
    logic signed [ACC_SIZE:0]  step_sh_reg [CHANNELS];
    logic signed [ACC_SIZE:0]  step_reg    [CHANNELS];
    logic [LUT_LENGTH-1:0]     off_sh_reg  [CHANNELS];
    logic [LUT_LENGTH-1:0]     off_reg     [CHANNELS];
    logic [CH_W-1:0]           slot_reg;

    logic [ACC_SIZE-1:0]       acc_cur;
    logic [ACC_SIZE-1:0]       acc_next;
    logic [LUT_LENGTH-1:0]     sin_phase;
    logic [LUT_LENGTH-1:0]     cos_phase;
    logic [CH_W-1:0]           slot_next;

    always_comb begin
        acc_cur   = acc_reg[slot_reg];
        acc_next  = acc_cur + step_reg[slot_reg][ACC_SIZE-1:0];
        sin_phase = acc_cur[ACC_SIZE-1 -: LUT_LENGTH] + off_reg[slot_reg];
        cos_phase = sin_phase + LUT_LENGTH'(Q);
        slot_next = (slot_reg == CH_W'(CHANNELS - 1)) ? '0 : slot_reg + 1'b1;
    end

    // Per-channel state; an active register sampled in the same cycle as apply
    // still sees its old value, and apply copies the pre-write shadow.
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_reg[gi]     <= '0;
                    step_sh_reg[gi] <= '0;
                    step_reg[gi]    <= '0;
                    off_sh_reg[gi]  <= '0;
                    off_reg[gi]     <= '0;
                end else begin
                    if (bus.cfg_clear)
                        acc_reg[gi] <= '0;
                    else if (bus.en && slot_reg == CH_W'(gi))
                        acc_reg[gi] <= acc_next;
                    if (bus.cfg_we && bus.cfg_ch == CH_W'(gi)) begin
                        step_sh_reg[gi] <= bus.cfg_step;
                        off_sh_reg[gi]  <= bus.cfg_offset;
                    end
                    if (bus.cfg_apply) begin
                        step_reg[gi] <= step_sh_reg[gi];
                        off_reg[gi]  <= off_sh_reg[gi];
                    end
                end
            end
        end
    endgenerate

    logic                s1_valid_reg;
    logic [CH_W-1:0]     s1_ch_reg;
    logic [AW:0]         s1_sin_map_reg;
    logic [AW:0]         s1_cos_map_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reg       <= '0;
            s1_valid_reg   <= 1'b0;
            s1_ch_reg      <= '0;
            s1_sin_map_reg <= '0;
            s1_cos_map_reg <= '0;
        end else begin
            s1_valid_reg <= bus.en;
            if (bus.en) begin
                slot_reg       <= slot_next;
                s1_ch_reg      <= slot_reg;
                s1_sin_map_reg <= quad_map(sin_phase);
                s1_cos_map_reg <= quad_map(cos_phase);
            end
        end
    end

    // Registered ROM read and sign application; data hold through bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_sin   <= '0;
            bus.out_cos   <= '0;
        end else begin
            bus.out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                bus.out_ch  <= s1_ch_reg;
                bus.out_sin <= s1_sin_map_reg[AW]
                             ? -$signed({1'b0, lut[s1_sin_map_reg[AW-1:0]]})
                             :  $signed({1'b0, lut[s1_sin_map_reg[AW-1:0]]});
                bus.out_cos <= s1_cos_map_reg[AW]
                             ? -$signed({1'b0, lut[s1_cos_map_reg[AW-1:0]]})
                             :  $signed({1'b0, lut[s1_cos_map_reg[AW-1:0]]});
            end
        end
    end
endmodule

// File: tb/tb_nco_tdm.sv
// Scoreboard bench for nco_tdm: the stimulus side models the oscillator with plain
// arithmetic and real-valued sin/cos; a monitor pops expectations on each output cycle.
module tb_nco_tdm;
    localparam int LUT_WIDTH  = 32;
    localparam int LUT_LENGTH = 6;
    localparam int PHASE_FRAC = 2;
    localparam int CHANNELS   = 4;
    localparam int ACC_SIZE   = LUT_LENGTH + PHASE_FRAC;
    localparam int N          = 2 ** LUT_LENGTH;
    localparam int MASK       = 2 ** ACC_SIZE - 1;
    localparam real PI        = 3.14159265358979323846;
    localparam real FS        = 4294967295.0;

    typedef struct {
        int     ch;
        longint s;
        longint c;
        int     t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;

    exp_t exp_q[$];

    int acc_m   [CHANNELS];
    int step_sh [CHANNELS];
    int step_act[CHANNELS];
    int off_sh  [CHANNELS];
    int off_act [CHANNELS];
    int slot_m;

    nco_tdm_if #(.LUT_WIDTH(LUT_WIDTH), .LUT_LENGTH(LUT_LENGTH),
                 .PHASE_FRAC(PHASE_FRAC), .CHANNELS(CHANNELS)) bus ();

    nco_tdm #(.LUT_WIDTH(LUT_WIDTH), .LUT_LENGTH(LUT_LENGTH),
              .PHASE_FRAC(PHASE_FRAC), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint ref_sin(input int p);
        return longint'(FS * $sin(2.0 * PI * real'(p) / real'(N)));
    endfunction

    function automatic longint ref_cos(input int p);
        return longint'(FS * $cos(2.0 * PI * real'(p) / real'(N)));
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            acc_m[c] = 0; step_sh[c] = 0; step_act[c] = 0; off_sh[c] = 0; off_act[c] = 0;
        end
        slot_m = 0;
    endtask

    // Drive one cycle of inputs, advance the reference model across the coming edge.
    task automatic tick(input bit e, input bit we, input int ch, input int stp,
                        input int off, input bit ap, input bit clr);
        int a;
        int p;
        int nacc;
        bus.en         = e;
        bus.cfg_we     = we;
        bus.cfg_ch     = ch[1:0];
        bus.cfg_step   = stp[ACC_SIZE:0];
        bus.cfg_offset = off[LUT_LENGTH-1:0];
        bus.cfg_apply  = ap;
        bus.cfg_clear  = clr;
        nacc = 0;
        if (e) begin
            a = acc_m[slot_m];
            p = ((a >> PHASE_FRAC) + off_act[slot_m]) % N;
            exp_q.push_back('{slot_m, ref_sin(p), ref_cos(p), cyc});
            $display("issue cyc=%0d ch=%0d p=%0d", cyc, slot_m, p);
            nacc = (a + step_act[slot_m]) & MASK;
        end
        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) acc_m[c] = 0;
        end else if (e) begin
            acc_m[slot_m] = nacc;
        end
        if (ap) begin
            for (int c = 0; c < CHANNELS; c++) begin
                step_act[c] = step_sh[c];
                off_act[c]  = off_sh[c];
            end
        end
        if (we) begin
            step_sh[ch] = stp;
            off_sh[ch]  = off;
        end
        if (e) slot_m = (slot_m + 1) % CHANNELS;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_apply = 1'b0; bus.cfg_clear = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_reset();
        check("reset_out_valid", longint'(bus.out_valid), 0);
        check("reset_out_ch",    longint'(bus.out_ch), 0);
        check("reset_out_sin",   longint'(bus.out_sin), 0);
        check("reset_out_cos",   longint'(bus.out_cos), 0);
        mon_on = 1'b1;
    endtask

    // Monitor: each cycle, out_valid must match whether an issued slot is due now.
    always @(negedge clk) begin
        if (mon_on && !reset) begin
            bit   due;
            exp_t e;
            due = (exp_q.size() > 0) && (exp_q[0].t + 2 == cyc);
            check("out_valid", longint'(bus.out_valid), longint'(due));
            if (due) begin
                e = exp_q.pop_front();
                if (bus.out_valid) begin
                    check("out_ch",  longint'(bus.out_ch), longint'(e.ch));
                    check("out_sin", longint'(bus.out_sin), e.s);
                    check("out_cos", longint'(bus.out_cos), e.c);
                    $display("sample cyc=%0d ch=%0d sin=%0d cos=%0d",
                             cyc, bus.out_ch, bus.out_sin, bus.out_cos);
                end
            end else if (exp_q.size() > 0 && exp_q[0].t + 2 < cyc) begin
                e = exp_q.pop_front();
                check("stale_expectation", longint'(cyc), longint'(e.t + 2));
            end
        end
    end

    initial begin
        bus.en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_step = '0;
        bus.cfg_offset = '0; bus.cfg_apply = 1'b0; bus.cfg_clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // ch0 unit LUT step through a full cycle
        tick(1'b0, 1'b1, 0, 4, 0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        run(260);

        // negative step, offset only, fractional step
        tick(1'b1, 1'b1, 1, -4, 0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 2, 0, 16, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 3, 1, 0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        run(40);
        tick(1'b1, 1'b1, 2, 0, 48, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        run(12);

        // bubbles
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        end

        // shadow then write+apply in the same cycle, then apply the new shadow
        tick(1'b1, 1'b1, 0, 8, 0, 1'b0, 1'b0);
        run(12);
        tick(1'b1, 1'b1, 0, 12, 0, 1'b1, 1'b0);
        run(12);
        tick(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        run(12);

        // clear while running, then reset mid-run
        tick(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        run(12);
        do_reset();
        run(12);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, CHANNELS - 1)),
                 int'($urandom_range(0, 511)) - 256,
                 int'($urandom_range(0, N - 1)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
        end

        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        check("queue_drained", longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
